// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Request/response bundle between the core's load/store path
//               and the data memory responder. Valid/ready on both channels.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
    // Request channel (core -> memory)
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    // Response channel (memory -> core)
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    // Status
    logic        busy;

    // Core side
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    // Memory side
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Word-organised data memory for the core's load/store stage.
//               One request outstanding at a time; the response is presented
//               a programmable number of cycles after the request is taken so
//               the core's stall logic sees a non-ideal memory.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_W  = 10,   // word-address width, depth = 2**ADDR_W
    parameter int LATENCY = 2     // acceptance-to-response cycles, 1..15
) (
    input  wire logic           clk,
    input  wire logic           rst,
    data_mem_responder_if.slave bus
);

    localparam int         c_depth    = 1 << ADDR_W;
    // Counter preload: the WAIT state leaves when the count reaches 1, so
    // the response appears exactly LATENCY cycles after acceptance.
    localparam logic [3:0] c_lat_load = 4'(LATENCY - 1);
    // With a single-cycle latency the WAIT state is skipped entirely.
    localparam bit         c_direct   = (LATENCY <= 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_busy;
    logic [31:0]         r_mem [c_depth];

    logic                w_range_err;
    logic                w_err;
    logic                w_accept;
    logic [ADDR_W-1:0]   w_idx;

    // Any address bit above the word index makes the access out of range;
    // addresses never alias onto a lower word.
    generate
        if (ADDR_W < 30) begin : g_range_chk
            assign w_range_err = |bus.req_addr[31:ADDR_W+2];
        end else begin : g_full_range
            assign w_range_err = 1'b0;
        end
    endgenerate

    assign w_idx    = bus.req_addr[ADDR_W+1:2];
    assign w_err    = (bus.req_addr[1:0] != 2'b00) | w_range_err;
    // Reset is folded in so a request presented while reset is held can
    // never commit a store into the array.
    assign w_accept = r_req_ready & bus.req_valid & ~rst;

    // Storage array: stores commit on the acceptance edge, byte by byte.
    // Faulting stores and unselected bytes leave the array untouched.
    always_ff @(posedge clk) begin
        if (w_accept && bus.req_write && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.req_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake outputs and response data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Load data is sampled now, so a later store
                        // cannot disturb an already-accepted load.
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (bus.req_write || w_err) ? 32'd0
                                                                : r_mem[w_idx];
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (c_direct) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_cnt       <= 4'd0;
                        end else begin
                            r_state     <= ST_WAIT;
                            r_cnt       <= c_lat_load;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt <= 4'd1) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_cnt       <= 4'd0;
                    end else begin
                        r_cnt       <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Response is held stable until the core takes it; the
                    // next request is only taken from the following cycle.
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= 4'd0;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                    r_rsp_err   <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Scoreboard bench for data_mem_responder. One instance runs
//               with a two-cycle latency and random response back-pressure,
//               a second with single-cycle latency and back-to-back traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int ADDR_W = 10;
    localparam int LAT_A  = 2;
    localparam int LAT_B  = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_responder_if a_if ();
    data_mem_responder_if b_if ();

    data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT_A)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT_B)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acc;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          a_hold = 0;
    exp_t        a_q [$];
    exp_t        b_q [$];
    logic [31:0] mdl_a [int];
    logic [31:0] mdl_b [int];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference memory: a sparse word array updated at acceptance time.
    function automatic exp_t model_step(input bit sel_b, input logic wr,
                                        input logic [31:0] addr, input logic [31:0] wd,
                                        input logic [3:0] be);
        exp_t        e;
        logic [31:0] w;
        int          idx;
        idx    = int'(addr >> 2);
        e.err  = (addr[1:0] != 2'b00) || (addr >= (32'd1 << (ADDR_W + 2)));
        e.data = 32'd0;
        e.acc  = cyc;
        if (!e.err) begin
            if (sel_b) w = mdl_b.exists(idx) ? mdl_b[idx] : 32'd0;
            else       w = mdl_a.exists(idx) ? mdl_a[idx] : 32'd0;
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
                if (sel_b) mdl_b[idx] = w;
                else       mdl_a[idx] = w;
            end else begin
                e.data = w;
            end
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_addr(input int max_word);
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0:       a = (32'($urandom_range(0, max_word)) << 2) | 32'($urandom_range(1, 3));
            1:       a = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
            default: a = 32'($urandom_range(0, max_word)) << 2;
        endcase
        return a;
    endfunction

    // Issue one request to instance A; called and returns on a falling edge.
    task automatic issue_a(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
        int g = 0;
        a_if.req_valid = 1'b1;
        a_if.req_write = wr;
        a_if.req_addr  = addr;
        a_if.req_wdata = wd;
        a_if.req_be    = be;
        while (!a_if.req_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!a_if.req_ready) begin
            fail_now("a_req_accept_timeout");
            a_if.req_valid = 1'b0;
            return;
        end
        a_q.push_back(model_step(1'b0, wr, addr, wd, be));
        @(negedge clk);
        a_if.req_valid = 1'b0;
    endtask

    // Back-to-back traffic on instance B with the response side always ready.
    task automatic run_b(input int n, input bit init);
        int          last = -1;
        int          g;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        for (int i = 0; i < n; i++) begin
            if (init) begin
                wr = 1'b1; addr = 32'(i) << 2; be = 4'hF;
            end else begin
                wr = 1'($urandom_range(0, 1)); addr = rand_addr(7); be = 4'($urandom_range(0, 15));
            end
            b_if.req_valid = 1'b1;
            b_if.req_write = wr;
            b_if.req_addr  = addr;
            b_if.req_wdata = $urandom;
            b_if.req_be    = be;
            g = 0;
            while (!b_if.req_ready && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (!b_if.req_ready) begin
                fail_now("b_req_accept_timeout");
                break;
            end
            if (last >= 0) chk("b_accept_spacing", 32'(cyc - last), 32'd2);
            last = cyc;
            b_q.push_back(model_step(1'b1, wr, addr, b_if.req_wdata, be));
            @(negedge clk);
        end
        b_if.req_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int g = 0;
        while ((a_q.size() != 0 || b_q.size() != 0) && g < budget) begin
            @(negedge clk);
            g++;
        end
        if (a_q.size() != 0 || b_q.size() != 0) fail_now("drain_timeout");
    endtask

    // Random response back-pressure on A, with a forced stall window.
    always @(posedge clk) begin
        #1;
        if (a_hold > 0) begin
            a_if.rsp_ready = 1'b0;
            a_hold--;
        end else begin
            a_if.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor A: latency, stability while stalled, and scoreboard compare.
    bit          a_seen = 1'b0;
    logic [31:0] a_hd;
    logic        a_he;
    exp_t        a_e;
    always @(negedge clk) begin
        if (rst) begin
            a_seen = 1'b0;
        end else if (a_if.rsp_valid) begin
            chk("a_req_ready_in_resp", 32'(a_if.req_ready), 32'd0);
            chk("a_busy_in_resp", 32'(a_if.busy), 32'd1);
            if (!a_seen) begin
                if (a_q.size() == 0) fail_now("a_unexpected_rsp");
                else chk("a_latency", 32'(cyc), 32'(a_q[0].acc + LAT_A));
            end else begin
                chk("a_stable_rdata", a_if.rsp_rdata, a_hd);
                chk("a_stable_err", 32'(a_if.rsp_err), 32'(a_he));
            end
            a_hd = a_if.rsp_rdata;
            a_he = a_if.rsp_err;
            if (a_if.rsp_ready && a_q.size() != 0) begin
                a_e = a_q.pop_front();
                chk("a_rdata", a_if.rsp_rdata, a_e.data);
                chk("a_err", 32'(a_if.rsp_err), 32'(a_e.err));
            end
            a_seen = !a_if.rsp_ready;
        end else begin
            a_seen = 1'b0;
        end
    end

    // Monitor B: single-cycle latency and scoreboard compare.
    exp_t b_e;
    always @(negedge clk) begin
        if (!rst && b_if.rsp_valid) begin
            if (b_q.size() == 0) begin
                fail_now("b_unexpected_rsp");
            end else begin
                b_e = b_q.pop_front();
                chk("b_latency", 32'(cyc), 32'(b_e.acc + LAT_B));
                chk("b_rdata", b_if.rsp_rdata, b_e.data);
                chk("b_err", 32'(b_if.rsp_err), 32'(b_e.err));
            end
        end
    end

    initial begin
        rst = 1'b1;
        a_if.req_valid = 1'b0; a_if.req_write = 1'b0; a_if.req_addr = '0;
        a_if.req_wdata = '0;   a_if.req_be = '0;      a_if.rsp_ready = 1'b0;
        b_if.req_valid = 1'b0; b_if.req_write = 1'b0; b_if.req_addr = '0;
        b_if.req_wdata = '0;   b_if.req_be = '0;      b_if.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_a_req_ready", 32'(a_if.req_ready), 32'd1);
        chk("rst_a_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
        chk("rst_a_rsp_rdata", a_if.rsp_rdata, 32'd0);
        chk("rst_a_rsp_err",   32'(a_if.rsp_err), 32'd0);
        chk("rst_a_busy",      32'(a_if.busy), 32'd0);
        chk("rst_b_req_ready", 32'(b_if.req_ready), 32'd1);
        chk("rst_b_rsp_valid", 32'(b_if.rsp_valid), 32'd0);
        chk("rst_b_busy",      32'(b_if.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Give every word the random traffic touches a known value.
        for (int w = 0; w < 16; w++) issue_a(1'b1, 32'(w) << 2, $urandom, 4'hF);

        // Full-word store and load back
        issue_a(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        issue_a(1'b0, 32'h10, 32'h0, 4'hF);

        // Single-byte store keeps the other bytes
        issue_a(1'b1, 32'h10, 32'h000000AA, 4'b0001);
        issue_a(1'b0, 32'h10, 32'h0, 4'h0);

        // Misaligned load, out-of-range store, word 0 untouched
        issue_a(1'b0, 32'h13, 32'h0, 4'hF);
        issue_a(1'b1, 32'h1000, 32'h12345678, 4'hF);
        issue_a(1'b0, 32'h0, 32'h0, 4'hF);

        // Stalled response; a pending request must wait for the handshake
        drain(100);
        a_hold = 8;
        issue_a(1'b0, 32'h10, 32'h0, 4'hF);
        @(negedge clk);
        a_if.req_valid = 1'b1; a_if.req_write = 1'b1; a_if.req_addr = 32'h10;
        a_if.req_wdata = 32'h5555_6666; a_if.req_be = 4'hF;
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", 32'(a_if.rsp_valid), 32'd1);
            chk("stall_req_ready", 32'(a_if.req_ready), 32'd0);
            @(negedge clk);
        end
        issue_a(1'b1, 32'h10, 32'h5555_6666, 4'hF);
        issue_a(1'b0, 32'h10, 32'h0, 4'hF);

        // Reset in the WAIT state of a store, then of a load
        drain(100);
        issue_a(1'b1, 32'h24, 32'hCAFE_F00D, 4'hF);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(a_if.req_ready), 32'd1);
        a_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        issue_a(1'b0, 32'h10, 32'h0, 4'hF);
        #2 rst = 1'b1;
        #1;
        chk("midrst2_rsp_valid", 32'(a_if.rsp_valid), 32'd0);
        chk("midrst2_req_ready", 32'(a_if.req_ready), 32'd1);
        chk("midrst2_busy", 32'(a_if.busy), 32'd0);
        a_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        issue_a(1'b0, 32'h24, 32'h0, 4'hF);
        issue_a(1'b0, 32'h10, 32'h0, 4'hF);

        // Randomised traffic on A
        for (int i = 0; i < 150; i++)
            issue_a(1'($urandom_range(0, 1)), rand_addr(15), $urandom, 4'($urandom_range(0, 15)));

        // Single-cycle latency, back-to-back on B
        run_b(8, 1'b1);
        run_b(40, 1'b0);

        drain(300);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
